// File: rtl/button_pulser.sv
// Push-button conditioner: synchronizer, debouncer and one-shot pulser
// with auto-repeat, feeding a downstream counter enable.
module button_pulser #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse,
    output logic pressed
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DLY_LAST = (REPEAT_DELAY > 0) ?
                                         TW'(REPEAT_DELAY - 1) : '0;
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    logic          s1;
    logic          s2;
    logic          stable;
    logic [DW-1:0] dcnt;
    state_t        state;
    state_t        state_d;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_d;
    logic          pulse_d;

    assign pressed = stable;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Accept a level change only after an unbroken run of differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= 1'b0;
            dcnt   <= '0;
        end else if (s2 != stable) begin
            if (dcnt == D_LAST) begin
                stable <= s2;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end else begin
            dcnt <= '0;
        end
    end

    // Pulser state, repeat timer and registered strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_d;
            tcnt  <= tcnt_d;
            pulse <= pulse_d;
        end
    end

    // First pulse on press, then delayed and periodic repeats while held.
    always_comb begin
        state_d = state;
        tcnt_d  = tcnt;
        pulse_d = 1'b0;
        unique case (state)
            IDLE: begin
                if (stable) begin
                    pulse_d = 1'b1;
                    tcnt_d  = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!stable) begin
                    state_d = IDLE;
                end else if (REPEAT_DELAY != 0) begin
                    if (tcnt == DLY_LAST) begin
                        pulse_d = 1'b1;
                        tcnt_d  = '0;
                        state_d = REPEAT;
                    end else begin
                        tcnt_d = tcnt + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (!stable) begin
                    state_d = IDLE;
                end else if (tcnt == PER_LAST) begin
                    pulse_d = 1'b1;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_button_pulser.sv
// Bench for button_pulser: edge-indexed behavioural model checked every
// cycle, plus literal pulse/pressed edge expectations per scenario.
module tb_button_pulser;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk;
    logic rst;
    logic btn;
    logic pulse;
    logic pressed;

    int total = 0;
    int bad   = 0;

    int e    = 0;
    int base = 0;

    int pulse_log[$];
    int exp_q[$];
    int rise_first;
    int fall_first;
    logic prev_pressed;

    logic q1, q2, p;
    int   run;
    int   rise_e;
    logic exp_pulse;

    button_pulser #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .pulse(pulse),
        .pressed(pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_pulses(input string name);
        chk({name, " count"}, pulse_log.size(), exp_q.size());
        if (pulse_log.size() == exp_q.size()) begin
            foreach (exp_q[i])
                chk({name, " edge"}, pulse_log[i], exp_q[i]);
        end
    endtask

    task automatic start_scn();
        base = e;
        pulse_log.delete();
        rise_first = -1;
        fall_first = -1;
    endtask

    task automatic press(input int hi, input int tail);
        btn = 1'b1;
        repeat (hi) @(negedge clk);
        btn = 1'b0;
        repeat (tail) @(negedge clk);
    endtask

    // Model: pressed follows the synchronized level after D differing
    // samples in a row; pulses land 1 edge after the rise, then RD edges
    // later, then every RP edges, for as long as pressed was high.
    always @(posedge clk) begin
        int ed;
        int dd;
        logic s2_pre;
        ed = e;
        e  = e + 1;
        exp_pulse = 1'b0;
        if (!rst) begin
            q1 = 1'b0;
            q2 = 1'b0;
            p = 1'b0;
            run = 0;
            rise_e = -1000;
        end else begin
            s2_pre = q2;
            if (p) begin
                dd = ed - rise_e;
                if (dd == 1)
                    exp_pulse = 1'b1;
                else if (RD > 0 && dd >= 1 + RD && ((dd - 1 - RD) % RP) == 0)
                    exp_pulse = 1'b1;
            end
            if (s2_pre != p) begin
                run++;
                if (run == D) begin
                    p = s2_pre;
                    run = 0;
                    if (p)
                        rise_e = ed;
                end
            end else begin
                run = 0;
            end
            q2 = q1;
            q1 = btn;
        end
        #1;
        total++;
        if (pulse !== exp_pulse || pressed !== p) begin
            bad++;
            $display("FAIL model edge=%0d: pulse=%b pressed=%b want %b %b",
                     ed - base, pulse, pressed, exp_pulse, p);
        end
        if (!rst) begin
            prev_pressed = 1'b0;
        end else begin
            if (pulse === 1'b1)
                pulse_log.push_back(ed - base);
            if (pressed === 1'b1 && prev_pressed !== 1'b1 && rise_first < 0)
                rise_first = ed - base;
            if (pressed === 1'b0 && prev_pressed === 1'b1 && fall_first < 0)
                fall_first = ed - base;
            prev_pressed = pressed;
        end
    end

    initial begin
        rst = 1'b0;
        btn = 1'b1;
        prev_pressed = 1'b0;
        start_scn();

        // Reset held with button high.
        repeat (4) begin
            @(negedge clk);
            chk("rst pulse", int'(pulse), 0);
            chk("rst pressed", int'(pressed), 0);
        end
        rst = 1'b1;
        start_scn();
        press(8, 25);
        exp_q = '{6};
        chk_pulses("post-rst");
        chk("post-rst rise", rise_first, 5);
        chk("post-rst fall", fall_first, 13);

        // Clean press.
        start_scn();
        press(8, 25);
        exp_q = '{6};
        chk_pulses("clean");
        chk("clean rise", rise_first, 5);
        chk("clean fall", fall_first, 13);

        // Glitch shorter than the debounce window.
        start_scn();
        press(3, 20);
        exp_q = {};
        chk_pulses("glitch");
        chk("glitch rise", rise_first, -1);

        // Bounce, then steady high from edge 6.
        start_scn();
        for (int i = 0; i < 6; i++) begin
            btn = (i % 2 == 0);
            @(negedge clk);
        end
        press(8, 25);
        exp_q = '{12};
        chk_pulses("bounce");
        chk("bounce rise", rise_first, 11);

        // Auto-repeat.
        start_scn();
        press(30, 25);
        exp_q = '{6, 16, 19, 22, 25, 28, 31, 34};
        chk_pulses("repeat");
        chk("repeat fall", fall_first, 35);

        // Reset while the first pulse is high.
        start_scn();
        btn = 1'b1;
        repeat (7) @(negedge clk);
        chk("mid pulse before rst", int'(pulse), 1);
        rst = 1'b0;
        #1;
        chk("mid pulse async", int'(pulse), 0);
        chk("mid pressed async", int'(pressed), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        start_scn();
        press(8, 25);
        exp_q = '{6};
        chk_pulses("mid post-rst");
        chk("mid post-rst rise", rise_first, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
